// File: rtl/fwd_pkg.sv
// Shared types and helpers for the scoreboard forwarding unit.
package fwd_pkg;

  localparam int FWD_ADDR_W     = 5;
  localparam int FWD_ADDR_MAX_W = 8;   // widest register address an entry can hold
  localparam int FWD_RDY_MAX_W  = 4;   // widest ready index an entry can hold (DEPTH <= 16)
  localparam int FWD_RF         = 0;   // select encoding: register-file value

  // An entry writes a register only when vld is set and dst is nonzero.
  // Non-writing instructions are stored with dst = 0.
  typedef struct packed {
    logic                      vld;
    logic [FWD_ADDR_MAX_W-1:0] dst;
    logic [FWD_RDY_MAX_W-1:0]  rdy;
  } fwd_ent_t;

  function automatic int fwd_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority lookup of one source operand against the in-flight entries.
// Produces a forwarding select or a hazard.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  logic [FWD_ADDR_MAX_W-1:0] src_i,
  input  logic                      use_i,
  input  fwd_ent_t [DEPTH-2:0]      ent_i,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      hazard_o
);

  // Scan oldest to youngest so the youngest live match is applied last and wins.
  always_comb begin
    sel_o    = SEL_W'(FWD_RF);
    hazard_o = 1'b0;
    if (use_i && (src_i != '0)) begin
      for (int k = DEPTH-2; k >= 0; k--) begin
        if (ent_i[k].vld && (ent_i[k].dst != '0) && (ent_i[k].dst == src_i)) begin
          if ((k + 1) > int'(ent_i[k].rdy)) begin
            sel_o    = SEL_W'(k + 1);
            hazard_o = 1'b0;
          end else begin
            sel_o    = SEL_W'(FWD_RF);
            hazard_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/forward_sb.sv
// Scoreboard forwarding/interlock unit at the decode/execute boundary.
// Tracks in-flight destinations, stalls decode on unready results and registers E-stage selects.
module forward_sb
  import fwd_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = FWD_ADDR_W,
  parameter int SEL_W   = fwd_clog2(DEPTH),
  parameter int RDY_W   = fwd_clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dec_valid,
  input  logic                      dec_wen,
  input  logic [ADDR_W-1:0]         dec_dst,
  input  logic [RDY_W-1:0]          dec_rdy,
  input  logic [NUM_SRC*ADDR_W-1:0] dec_src,
  input  logic [NUM_SRC-1:0]        dec_use,
  input  logic                      hold,
  input  logic                      flush,
  output logic                      stall_d,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_e,
  output logic                      e_valid
);

  // The last stage retires on the edge it is looked up and the register file
  // already supplies its value, so only entries 0..DEPTH-2 are stored.
  localparam int NE = DEPTH - 1;

  fwd_ent_t [NE-1:0]             ent_q, ent_d;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel_q, sel_d, sel_w;
  logic [NUM_SRC-1:0]            haz_w;
  logic                          issue;
  fwd_ent_t                      new_ent;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .src_i    (FWD_ADDR_MAX_W'(dec_src[i*ADDR_W +: ADDR_W])),
      .use_i    (dec_use[i]),
      .ent_i    (ent_q),
      .sel_o    (sel_w[i]),
      .hazard_o (haz_w[i])
    );
  end

  assign stall_d   = hold | (dec_valid & (|haz_w));
  assign issue     = dec_valid & ~stall_d;
  assign fwd_sel_e = sel_q;
  assign e_valid   = ent_q[0].vld;

  always_comb begin
    new_ent     = '0;
    new_ent.vld = 1'b1;
    new_ent.dst = dec_wen ? FWD_ADDR_MAX_W'(dec_dst) : '0;
    new_ent.rdy = (int'(dec_rdy) >= DEPTH - 1) ? FWD_RDY_MAX_W'(DEPTH - 2)
                                                : FWD_RDY_MAX_W'(dec_rdy);
  end

  always_comb begin
    ent_d = ent_q;
    sel_d = sel_q;
    if (flush) begin
      ent_d = '0;
      sel_d = '0;
    end else if (!hold) begin
      for (int k = NE-1; k >= 1; k--) ent_d[k] = ent_q[k-1];
      ent_d[0] = issue ? new_ent : '0;
      sel_d    = issue ? sel_w   : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
      sel_q <= '0;
    end else begin
      ent_q <= ent_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: tb/tb_forward_sb.sv
// Directed vector bench for forward_sb at DEPTH=3, NUM_SRC=2.
module tb_forward_sb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_valid, dec_wen, hold, flush;
  logic [4:0] dec_dst;
  logic [1:0] dec_rdy, dec_use;
  logic [9:0] dec_src;
  logic       stall_d, e_valid;
  logic [3:0] fwd_sel_e;

  int n_chk  = 0;
  int n_fail = 0;

  forward_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dec_valid (dec_valid),
    .dec_wen   (dec_wen),
    .dec_dst   (dec_dst),
    .dec_rdy   (dec_rdy),
    .dec_src   (dec_src),
    .dec_use   (dec_use),
    .hold      (hold),
    .flush     (flush),
    .stall_d   (stall_d),
    .fwd_sel_e (fwd_sel_e),
    .e_valid   (e_valid)
  );

  always #5 clk = ~clk;

  // Inputs for one cycle plus outputs expected before that cycle's edge:
  // stall for this cycle, e_valid/selects left by the previous edge.
  typedef struct {
    logic       v, w;
    logic [4:0] d;
    logic [1:0] r;
    logic [4:0] s0, s1;
    logic [1:0] u;
    logic       h, f;
    logic       es, ev;
    logic [1:0] e0, e1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(int v, int w, int d, int r, int s0, int s1, int u,
                             int h, int f, int es, int ev, int e0, int e1);
    vec_t t;
    t.v  = 1'(v);  t.w  = 1'(w);  t.d  = 5'(d);  t.r  = 2'(r);
    t.s0 = 5'(s0); t.s1 = 5'(s1); t.u  = 2'(u);  t.h  = 1'(h);
    t.f  = 1'(f);  t.es = 1'(es); t.ev = 1'(ev); t.e0 = 2'(e0);
    t.e1 = 2'(e1);
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    dec_valid = t.v;  dec_wen = t.w;  dec_dst = t.d;  dec_rdy = t.r;
    dec_src   = {t.s1, t.s0};  dec_use = t.u;  hold = t.h;  flush = t.f;
  endtask

  task automatic check_out(input int idx, input logic es, input logic ev,
                           input logic [1:0] e0, input logic [1:0] e1);
    chk("stall_d", idx, 8'(stall_d), 8'(es));
    chk("e_valid", idx, 8'(e_valid), 8'(ev));
    chk("sel0",    idx, 8'(fwd_sel_e[1:0]), 8'(e0));
    chk("sel1",    idx, 8'(fwd_sel_e[3:2]), 8'(e1));
  endtask

  initial begin
    apply(V(0,0,0,0,0,0,0,0,0,0,0,0,0));
    #2;
    check_out(-1, 1'b0, 1'b0, 2'd0, 2'd0);
    hold = 1'b1;
    #1;
    chk("stall_hold_rst", -1, 8'(stall_d), 8'd1);
    hold = 1'b0;

    //              v w  d r s0 s1 u h f  es ev e0 e1
    // ALU to consumer, gap 0/1/2
    tbl.push_back(V(1,1, 3,0, 0, 0,0,0,0, 0,0,0,0));  // 0  addu $3
    tbl.push_back(V(1,0, 0,0, 3, 0,1,0,0, 0,1,0,0));  // 1  use $3
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,1,0));  // 2
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(V(1,1, 4,0, 0, 0,0,0,0, 0,0,0,0));  // 5  addu $4
    tbl.push_back(V(1,1, 9,0, 0, 0,0,0,0, 0,1,0,0));
    tbl.push_back(V(1,0, 0,0, 0, 4,2,0,0, 0,1,0,0));  // 7  src1 = $4, gap 1
    tbl.push_back(V(1,1, 6,0, 0, 0,0,0,0, 0,1,0,2));  // 8  addu $6
    tbl.push_back(V(1,0, 0,0, 0, 0,0,0,0, 0,1,0,0));
    tbl.push_back(V(1,0, 0,0, 0, 0,0,0,0, 0,1,0,0));
    tbl.push_back(V(1,0, 0,0, 6, 6,3,0,0, 0,1,0,0));  // 11 gap 2 -> RF
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    // load-use
    tbl.push_back(V(1,1, 5,1, 0, 0,0,0,0, 0,0,0,0));  // 14 lw $5
    tbl.push_back(V(1,0, 0,0, 5, 0,1,0,0, 1,1,0,0));  // 15 stall
    tbl.push_back(V(1,0, 0,0, 5, 0,1,0,0, 0,0,0,0));  // 16 issue, bubble in E
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,2,0));
    tbl.push_back(V(1,0, 0,0, 5, 0,1,0,0, 0,0,0,0));  // 18 lw in last stage
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,0,0));
    // $0 and use gating
    tbl.push_back(V(1,1, 0,1, 0, 0,0,0,0, 0,0,0,0));  // 20 lw $0
    tbl.push_back(V(1,0, 0,0, 0, 0,3,0,0, 0,1,0,0));
    tbl.push_back(V(1,1, 8,1, 0, 0,0,0,0, 0,1,0,0));  // 22 lw $8
    tbl.push_back(V(1,0, 0,0, 0, 8,1,0,0, 0,1,0,0));  // 23 src1 unused
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    // youngest wins
    tbl.push_back(V(1,1, 7,1, 0, 0,0,0,0, 0,0,0,0));  // 26 lw $7
    tbl.push_back(V(1,1, 7,0, 0, 0,0,0,0, 0,1,0,0));  // 27 addu $7
    tbl.push_back(V(1,0, 0,0, 7, 0,1,0,0, 0,1,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,1,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(V(1,1, 7,0, 0, 0,0,0,0, 0,0,0,0));  // 31 addu $7
    tbl.push_back(V(1,1, 7,1, 0, 0,0,0,0, 0,1,0,0));  // 32 lw $7
    tbl.push_back(V(1,0, 0,0, 7, 0,1,0,0, 1,1,0,0));
    tbl.push_back(V(1,0, 0,0, 7, 0,1,0,0, 0,0,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,2,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    // hold during load-use
    tbl.push_back(V(1,1, 5,1, 0, 0,0,0,0, 0,0,0,0));  // 37 lw $5
    tbl.push_back(V(1,0, 0,0, 5, 0,1,1,0, 1,1,0,0));
    tbl.push_back(V(1,0, 0,0, 5, 0,1,1,0, 1,1,0,0));
    tbl.push_back(V(1,0, 0,0, 5, 0,1,1,0, 1,1,0,0));
    tbl.push_back(V(1,0, 0,0, 5, 0,1,0,0, 1,1,0,0));  // 41 released: stall once
    tbl.push_back(V(1,0, 0,0, 5, 0,1,0,0, 0,0,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,1,0, 1,1,2,0));  // 43 hold keeps sel
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,2,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    // flush
    tbl.push_back(V(1,1,10,0, 0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(V(1,1,11,1, 0, 0,0,0,0, 0,1,0,0));
    tbl.push_back(V(1,0, 0,0,11,10,3,0,1, 1,1,0,0));  // 48 flush
    tbl.push_back(V(1,0, 0,0,11,10,3,0,0, 0,0,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,1,1, 1,1,0,0));  // 50 flush beats hold
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(V(1,1,12,0, 0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(V(1,0, 0,0,12, 0,1,0,0, 0,1,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,1,1, 1,1,1,0));  // 54
    tbl.push_back(V(1,0, 0,0,12, 0,1,0,0, 0,0,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,0,0));
    // dec_rdy = 3 saturates to 1
    tbl.push_back(V(1,1,20,3, 0, 0,0,0,0, 0,0,0,0));  // 57
    tbl.push_back(V(1,0, 0,0,20, 0,1,0,0, 1,1,0,0));
    tbl.push_back(V(1,0, 0,0,20, 0,1,0,0, 0,0,0,0));
    tbl.push_back(V(0,0, 0,0, 0, 0,0,0,0, 0,1,2,0));

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check_out(i, tbl[i].es, tbl[i].ev, tbl[i].e0, tbl[i].e1);
    end

    // Reset with three live entries
    @(negedge clk); apply(V(1,1,13,0, 0, 0,0,0,0, 0,0,0,0));
    @(negedge clk); apply(V(1,1,14,0,13, 0,1,0,0, 0,0,0,0));
    @(negedge clk); apply(V(1,1,15,1,14, 0,1,0,0, 0,0,0,0));
    @(negedge clk); apply(V(1,0, 0,0,15,14,3,0,0, 0,0,0,0));
    #1;
    check_out(100, 1'b1, 1'b1, 2'd1, 2'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_out(101, 1'b0, 1'b0, 2'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("stall_post_rst", 102, 8'(stall_d), 8'd0);
    @(negedge clk);
    apply(V(0,0,0,0,0,0,0,0,0,0,0,0,0));
    #1;
    check_out(103, 1'b0, 1'b1, 2'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
